// File: rtl/spi_xfer_master.sv
// SPI master: one DATA_W-bit full-duplex transfer per command.
// Runtime CPOL/CPHA, bit order and chip select, latched per command.
module spi_xfer_master #(
  parameter int DATA_W  = 24,
  parameter int CLK_DIV = 4,
  parameter int NUM_CS  = 2,
  localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [CSW-1:0]    cmd_cs,
  input  logic              cmd_cpol,
  input  logic              cmd_cpha,
  input  logic              cmd_lsb_first,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sck,
  output logic [NUM_CS-1:0] csn,
  output logic              mosi,
  input  logic              miso
);

  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int EW   = $clog2(2 * DATA_W + 1);
  localparam logic [CW-1:0] CNT_TOP   = CW'(HALF - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_HOLD
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_cnt;
  logic [EW-1:0]     r_ecnt;
  logic [CSW-1:0]    r_cs;
  logic              r_cpol;
  logic              r_cpha;
  logic              r_lsb;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic              r_mosi;
  logic              r_sck;
  logic              r_rx_valid;
  logic [DATA_W-1:0] r_rx_data;
  logic [NUM_CS-1:0] w_csn;

  logic w_idle;
  logic w_accept;
  logic w_tick;
  logic w_edge;
  logic w_lead;
  logic w_trail;
  logic w_shift;
  logic w_samp;
  logic w_last;

  function automatic logic f_first(
    input logic [DATA_W-1:0] w,
    input logic              lsb
  );
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] f_shift(
    input logic [DATA_W-1:0] w,
    input logic              lsb
  );
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle && cmd_valid;
  assign w_tick   = (r_cnt == '0);
  // sck toggles at the end of every half period inside XFER
  assign w_edge   = (r_state == S_XFER) && w_tick;
  assign w_lead   = w_edge && !r_ecnt[0];
  assign w_trail  = w_edge && r_ecnt[0];
  assign w_shift  = r_cpha ? w_lead : w_trail;
  assign w_samp   = r_cpha ? w_trail : w_lead;
  assign w_last   = w_edge && (r_ecnt == EDGE_LAST);

  assign cmd_ready = w_idle;
  assign busy      = !w_idle;
  assign sck       = r_sck;
  assign csn       = w_csn;
  assign mosi      = (&w_csn) ? 1'b0 : r_mosi;
  assign rx_valid  = r_rx_valid;
  assign rx_data   = r_rx_data;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (cmd_valid) w_next = S_SETUP;
      S_SETUP: if (w_tick)    w_next = S_XFER;
      S_XFER:  if (w_last)    w_next = S_HOLD;
      S_HOLD:  if (w_tick)    w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  // Chip select decode; out-of-range index selects nothing
  always_comb begin
    w_csn = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (!w_idle && r_cs == CSW'(i)) w_csn[i] = 1'b0;
    end
  end

  // Command latch, sck generation, shifting and completion
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= CNT_TOP;
      r_ecnt     <= '0;
      r_cs       <= '0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_mosi     <= 1'b0;
      r_sck      <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_idle || w_tick) r_cnt <= CNT_TOP;
      else                  r_cnt <= r_cnt - 1'b1;
      if (w_accept) begin
        r_cs   <= cmd_cs;
        r_cpol <= cmd_cpol;
        r_cpha <= cmd_cpha;
        r_lsb  <= cmd_lsb_first;
        r_sck  <= cmd_cpol;
        r_ecnt <= '0;
        r_rx   <= '0;
        if (cmd_cpha) begin
          r_mosi <= 1'b0;
          r_tx   <= cmd_data;
        end else begin
          r_mosi <= f_first(cmd_data, cmd_lsb_first);
          r_tx   <= f_shift(cmd_data, cmd_lsb_first);
        end
      end
      if (w_edge) begin
        r_sck  <= ~r_sck;
        r_ecnt <= r_ecnt + 1'b1;
      end
      if (w_shift) begin
        r_mosi <= f_first(r_tx, r_lsb);
        r_tx   <= f_shift(r_tx, r_lsb);
      end
      if (w_samp) begin
        if (r_lsb) r_rx <= {miso, r_rx[DATA_W-1:1]};
        else       r_rx <= {r_rx[DATA_W-2:0], miso};
      end
      if (r_state == S_HOLD && w_tick) begin
        r_rx_valid <= 1'b1;
        r_rx_data  <= r_rx;
      end
    end
  end

endmodule

// File: tb/tb_spi_xfer_master.sv
// Bench for spi_xfer_master: vector table, scoreboard queue,
// SPI slave model, plus reset-abort, back-to-back and NUM_CS=1 cases.
module tb_spi_xfer_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [23:0] cmd_data = '0;
  logic        cmd_cs = 1'b0;
  logic        cmd_cpol = 1'b0;
  logic        cmd_cpha = 1'b0;
  logic        cmd_lsb_first = 1'b0;
  logic        rx_valid;
  logic [23:0] rx_data;
  logic        busy;
  logic        sck;
  logic [1:0]  csn;
  logic        mosi;
  logic        miso;

  logic        v1 = 1'b0;
  logic        ready1;
  logic        rx_valid1;
  logic [23:0] rx_data1;
  logic        busy1;
  logic        sck1;
  logic        csn1;
  logic        mosi1;
  logic        miso1 = 1'b1;

  logic        loop = 1'b1;
  logic        slv_miso = 1'b0;

  assign miso = loop ? mosi : slv_miso;

  always #5 clk = ~clk;

  spi_xfer_master #(
    .DATA_W(24), .CLK_DIV(4), .NUM_CS(2)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_cs(cmd_cs),
    .cmd_cpol(cmd_cpol), .cmd_cpha(cmd_cpha),
    .cmd_lsb_first(cmd_lsb_first),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .busy(busy), .sck(sck), .csn(csn),
    .mosi(mosi), .miso(miso)
  );

  spi_xfer_master #(
    .DATA_W(24), .CLK_DIV(4), .NUM_CS(1)
  ) dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid(v1), .cmd_ready(ready1),
    .cmd_data(cmd_data), .cmd_cs(cmd_cs),
    .cmd_cpol(cmd_cpol), .cmd_cpha(cmd_cpha),
    .cmd_lsb_first(cmd_lsb_first),
    .rx_valid(rx_valid1), .rx_data(rx_data1),
    .busy(busy1), .sck(sck1), .csn(csn1),
    .mosi(mosi1), .miso(miso1)
  );

  typedef struct packed {
    logic [23:0] data;
    logic        cs;
    logic        cpol;
    logic        cpha;
    logic        lsb;
    logic        loop;
    logic [23:0] slave;
    logic [23:0] rx;
    logic [1:0]  csn;
  } vec_t;

  typedef struct packed {
    logic [23:0] rx;
    logic [23:0] tx;
    logic [1:0]  csn;
    logic        cpol;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[5];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, got, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  // slave model and rx monitor, sampled on the falling clk edge
  int          cyc = 0;
  int          fall_cyc = 0;
  int          s_edges = 0;
  int          n_rxv = 0;
  int          rx_last = 0;
  int          rx_prev = 0;
  logic        p_sck = 1'b0;
  logic [1:0]  p_csn = 2'b11;
  logic [1:0]  fall_csn = 2'b11;
  logic        fall_sck = 1'b0;
  logic [23:0] s_word = '0;
  logic [23:0] s_sh = '0;
  logic [23:0] s_rx = '0;
  logic        s_cpha = 1'b0;
  logic        s_lsb = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    logic lead;
    cyc++;
    if (csn != 2'b11 && p_csn == 2'b11) begin
      fall_cyc = cyc;
      fall_csn = csn;
      fall_sck = sck;
      s_edges  = 0;
      s_rx     = '0;
      s_sh     = s_word;
      if (!s_cpha) begin
        slv_miso = s_lsb ? s_sh[0] : s_sh[23];
        s_sh = s_lsb ? (s_sh >> 1) : (s_sh << 1);
      end
    end else if (csn != 2'b11 && sck != p_sck) begin
      s_edges++;
      lead = s_edges[0];
      if (lead != s_cpha) begin
        if (s_lsb) s_rx = {mosi, s_rx[23:1]};
        else       s_rx = {s_rx[22:0], mosi};
      end else begin
        slv_miso = s_lsb ? s_sh[0] : s_sh[23];
        s_sh = s_lsb ? (s_sh >> 1) : (s_sh << 1);
      end
    end
    if (rx_valid === 1'b1) begin
      n_rxv++;
      rx_prev = rx_last;
      rx_last = cyc;
      if (sb.size() == 0) begin
        fail("rx_unexpected");
      end else begin
        e = sb.pop_front();
        check("rx_data", 32'(rx_data), 32'(e.rx));
        check("rx_latency", 32'(cyc - fall_cyc), 32'd100);
        check("sck_edges", 32'(s_edges), 32'd48);
        check("tx_seen", 32'(s_rx), 32'(e.tx));
        check("csn_active", 32'(fall_csn), 32'(e.csn));
        check("sck_idle_setup", 32'(fall_sck), 32'(e.cpol));
      end
    end
    p_csn = csn;
    p_sck = sck;
  end

  task automatic wait_ready();
    for (int k = 0; k < 300 && cmd_ready !== 1'b1; k++)
      @(negedge clk);
    if (cmd_ready !== 1'b1) fail("ready_timeout");
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300 && sb.size() > 0; k++)
      @(negedge clk);
    if (sb.size() != 0) begin
      fail("rx_timeout");
      sb.delete();
    end
  endtask

  task automatic drive_cmd(input vec_t v);
    s_word   = v.slave;
    s_cpha   = v.cpha;
    s_lsb    = v.lsb;
    loop     = v.loop;
    cmd_data = v.data;
    cmd_cs   = v.cs;
    cmd_cpol = v.cpol;
    cmd_cpha = v.cpha;
    cmd_lsb_first = v.lsb;
    cmd_valid = 1'b1;
    @(posedge clk);
    sb.push_back({v.rx, v.data, v.csn, v.cpol});
  endtask

  task automatic run_xfer(input vec_t v);
    @(negedge clk);
    wait_ready();
    drive_cmd(v);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("ready_while_busy", 32'(cmd_ready), 32'd0);
    repeat (10) @(negedge clk);
    cmd_data = ~v.data;
    cmd_cs   = ~v.cs;
    cmd_cpol = ~v.cpol;
    cmd_cpha = ~v.cpha;
    cmd_lsb_first = ~v.lsb;
    cmd_valid = 1'b1;
    repeat (4) @(negedge clk);
    cmd_valid = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);
    check("rx_hold", 32'(rx_data), 32'(v.rx));
    check("sck_idle_after", 32'(sck), 32'(v.cpol));
    check("csn_idle", 32'(csn), 32'd3);
    check("mosi_idle", 32'(mosi), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   n;
    int   st;
    int   rv;
    int   bad;

    vecs[0] = {24'hABCDEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
               24'h000000, 24'hABCDEF, 2'b10};
    vecs[1] = {24'hABCDEF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
               24'hFEDCBA, 24'hFEDCBA, 2'b01};
    vecs[2] = {24'h000001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
               24'h000000, 24'h000001, 2'b10};
    vecs[3] = {24'h123456, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
               24'h5A5A5A, 24'h5A5A5A, 2'b01};
    vecs[4] = {24'h0F1E2D, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
               24'hC3A5F0, 24'hC3A5F0, 2'b10};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_csn", 32'(csn), 32'd3);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 5; i++) run_xfer(vecs[i]);

    // back-to-back with cmd_valid held high
    v = {24'h3C3C3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
         24'h000000, 24'h3C3C3C, 2'b10};
    @(negedge clk);
    wait_ready();
    drive_cmd(v);
    #1 cmd_data = 24'h96A5C3;
    v.data = 24'h96A5C3;
    v.rx   = 24'h96A5C3;
    @(negedge clk);
    wait_ready();
    check("b2b_gap_csn", 32'(csn), 32'd3);
    @(posedge clk);
    sb.push_back({v.rx, v.data, v.csn, v.cpol});
    #1 cmd_valid = 1'b0;
    wait_drain();
    check("b2b_rx_spacing", 32'(rx_last - rx_prev), 32'd101);

    // reset in the middle of a transfer
    v = {24'h55AA33, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
         24'h000000, 24'h55AA33, 2'b01};
    @(negedge clk);
    wait_ready();
    drive_cmd(v);
    #1 cmd_valid = 1'b0;
    for (int k = 0; k < 200 && s_edges < 10; k++)
      @(negedge clk);
    if (s_edges < 10) fail("abort_edge_timeout");
    rst = 1'b1;
    n = n_rxv;
    @(posedge clk);
    sb.delete();
    @(negedge clk);
    check("abort_sck", 32'(sck), 32'd0);
    check("abort_csn", 32'(csn), 32'd3);
    check("abort_mosi", 32'(mosi), 32'd0);
    check("abort_rx_valid", 32'(rx_valid), 32'd0);
    check("abort_rx_data", 32'(rx_data), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check("abort_no_rx", 32'(n_rxv), 32'(n));
    run_xfer(vecs[0]);

    // NUM_CS=1 instance with an out-of-range chip select
    @(negedge clk);
    cmd_data = 24'h0F0F0F;
    cmd_cs   = 1'b1;
    cmd_cpol = 1'b0;
    cmd_cpha = 1'b0;
    cmd_lsb_first = 1'b0;
    v1 = 1'b1;
    @(posedge clk);
    #1 v1 = 1'b0;
    st = -1;
    rv = -1;
    bad = 0;
    for (int k = 0; k < 200 && rv < 0; k++) begin
      @(negedge clk);
      if (busy1 === 1'b1 && st < 0) st = k;
      if (csn1 !== 1'b1 || mosi1 !== 1'b0) bad++;
      if (rx_valid1 === 1'b1) rv = k;
    end
    if (st < 0 || rv < 0) begin
      fail("cs1_timeout");
    end else begin
      check("cs1_latency", 32'(rv - st), 32'd100);
    end
    check("cs1_csn_mosi_bad", 32'(bad), 32'd0);
    check("cs1_rx_data", 32'(rx_data1), 32'hFFFFFF);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_xfer_master.md
SPI_XFER_MASTER -- requirements
Module: spi_xfer_master

Interface
REQ-001 SHALL have parameter DATA_W, default 24, bits per transfer (>=2).
REQ-002 SHALL have parameter CLK_DIV, default 4, sck period in clk cycles (even, >=2).
REQ-003 SHALL have parameter NUM_CS, default 2, number of chip selects (>=1).
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port cmd_valid, input, 1, command request.
REQ-007 SHALL have port cmd_ready, output, 1, command accept-ready.
REQ-008 SHALL have port cmd_data, input, DATA_W, transmit word.
REQ-009 SHALL have port cmd_cs, input, max(1,$clog2(NUM_CS)), chip-select index.
REQ-010 SHALL have port cmd_cpol, input, 1, sck idle level.
REQ-011 SHALL have port cmd_cpha, input, 1, 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-012 SHALL have port cmd_lsb_first, input, 1, bit order.
REQ-013 SHALL have port rx_valid, output, 1, one-cycle pulse when a received word is valid.
REQ-014 SHALL have port rx_data, output, DATA_W, received word.
REQ-015 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-016 SHALL have port sck, output, 1, SPI clock.
REQ-017 SHALL have port csn, output, NUM_CS, active-low chip selects.
REQ-018 SHALL have port mosi, output, 1, serial data out.
REQ-019 SHALL have port miso, input, 1, serial data in.

Function
REQ-020 SHALL implement FSM IDLE -> SETUP -> XFER -> HOLD -> IDLE.
REQ-021 SHALL drive cmd_ready=1 only in IDLE; accept on cmd_valid&&cmd_ready; latch data, cs, cpol, cpha, lsb_first on that cycle.
REQ-022 SHALL hold sck at the latched cpol in IDLE, SETUP and HOLD; cpol is 0 after reset until the first accept.
REQ-023 SHALL assert csn[cmd_cs] low from the cycle after accept until the end of HOLD; other csn bits stay high.
REQ-024 SHALL, for cmd_cs >= NUM_CS, keep all csn high but otherwise run the full transfer, including rx_valid.
REQ-025 SHALL last CLK_DIV/2 cycles in SETUP, DATA_W*CLK_DIV cycles in XFER (sck toggling every CLK_DIV/2 cycles, 2*DATA_W edges), and CLK_DIV/2 cycles in HOLD.
REQ-026 SHALL, when cpha=0, present the first bit on mosi at SETUP entry, sample miso on each leading (odd) edge, and shift mosi on each trailing edge.
REQ-027 SHALL, when cpha=1, shift mosi on each leading edge, with the first bit on the first leading edge, and sample miso on each trailing edge.
REQ-028 SHALL shift out MSB first when lsb_first=0 and LSB first when lsb_first=1; rx bits SHALL be assembled in the same order.
REQ-029 SHALL drive mosi=0 whenever all csn are high.
REQ-030 SHALL pulse rx_valid for exactly one cycle on the cycle csn returns high, which is (DATA_W+1)*CLK_DIV cycles after csn fell; rx_data updates only then and holds until the next completion.
REQ-031 SHALL assert cmd_ready the cycle after HOLD ends, guaranteeing csn high for at least 1 cycle between transfers; a cmd_valid held high SHALL start the next transfer then.
REQ-032 SHALL ignore cmd_* inputs while busy.

Reset
REQ-033 SHALL, on rst=1 at any clock edge, including mid-transfer, go to IDLE with sck=0, csn all 1, mosi=0, rx_valid=0, rx_data=0, busy=0, cmd_ready=1 on the next cycle.
REQ-034 SHALL NOT pulse rx_valid for an aborted transfer.

Verification (DATA_W=24, CLK_DIV=4, NUM_CS=2)
REQ-035 Mode 0, cs=0, data 0xABCDEF, miso looped to mosi -> csn=2'b10, 48 sck edges, rx_valid 100 cycles after csn fall, rx_data=0xABCDEF.
REQ-036 Mode 3, cs=1, slave model returns 0xFEDCBA -> sck idles high, csn=2'b01, rx_data=0xFEDCBA, tx observed 0xABCDEF.
REQ-037 lsb_first=1, data 0x000001 -> mosi=1 for the first bit only; looped rx_data=0x000001.
REQ-038 cmd_valid held high for two commands -> two transfers, csn high >=1 cycle between them, two rx_valid pulses 101+ cycles apart.
REQ-039 rst asserted after the 10th sck edge -> reset values on the next cycle, no rx_valid, new command completes normally.
REQ-040 cmd_cs=1 with NUM_CS=1 -> csn stays 1'b1, rx_valid still 100 cycles after start of SETUP.
